dec_key_entry_ctrl: RTL and testbench

//  Sequences the 10-line decimal-to-BCD encoder (inputs ENC_B/ENC_CHK are its B/CHK outputs).

---
 rtl/dec_key_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_dec_key_entry_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_key_entry_ctrl.sv
// dec_key_entry_ctrl
//   Sequences a 10-line decimal-to-BCD keypad encoder. Debounces key press
//   and release, rejects codes above 9 (multi-key combinations), collects
//   NUM_DIGITS accepted digits and hands the number downstream with a
//   valid/ready handshake.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high, overrides every input
//   enc_b_i      encoder BCD code
//   enc_chk_i    encoder key-present flag (1 = some key down, key 0 included)
//   clr_i        cancel the current entry
//   ready_i      downstream accepts digits_o while valid_o is high
//   digits_o     entered number, first digit in the MS nibble, newest in [3:0]
//   count_o      digits accepted so far
//   valid_o      full entry available
//   key_ack_o    1-cycle pulse: digit accepted
//   key_err_o    1-cycle pulse: stable code above 9 rejected
module dec_key_entry_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [3:0]                        enc_b_i,
  input  logic                              enc_chk_i,
  input  logic                              clr_i,
  input  logic                              ready_i,
  output logic [4*NUM_DIGITS-1:0]           digits_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count_o,
  output logic                              valid_o,
  output logic                              key_ack_o,
  output logic                              key_err_o
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int NW = $clog2(DEBOUNCE_CYCLES);

  // Last value of the debounce counter before a press/release is declared.
  localparam logic [NW-1:0] CNT_MAX    = NW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE,
    ST_DONE
  } state_e;

  state_e          state_q;
  logic [NW-1:0]   cnt_q;
  logic [3:0]      code_q;
  logic [DW-1:0]   digits_q;
  logic [CW-1:0]   count_q;
  logic            valid_q;
  logic            key_ack_q;
  logic            key_err_q;
  logic [DW-1:0]   digits_shift;

  // Buffer with the latched code shifted in at the LS nibble. A one-digit
  // buffer has nothing to shift, so it simply takes the code.
  generate
    if (NUM_DIGITS == 1) begin : g_one_digit
      assign digits_shift = code_q;
    end else begin : g_multi_digit
      assign digits_shift = {digits_q[DW-5:0], code_q};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      digits_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      key_ack_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      key_ack_q <= 1'b0;
      key_err_q <= 1'b0;
      if (clr_i) begin
        // Cancel goes through RELEASE so a key still held is not re-captured.
        digits_q <= '0;
        count_q  <= '0;
        valid_q  <= 1'b0;
        cnt_q    <= '0;
        state_q  <= ST_RELEASE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // This edge is the first of the DEBOUNCE_CYCLES samples.
            if (enc_chk_i) begin
              code_q  <= enc_b_i;
              cnt_q   <= NW'(1);
              state_q <= ST_PRESS;
            end
          end
          ST_PRESS: begin
            if (!enc_chk_i) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else if (enc_b_i != code_q) begin
              code_q <= enc_b_i;
              cnt_q  <= NW'(1);
            end else if (cnt_q < CNT_MAX) begin
              cnt_q <= cnt_q + NW'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= ST_RELEASE;
              if (code_q <= 4'd9) begin
                digits_q  <= digits_shift;
                count_q   <= count_q + CW'(1);
                key_ack_q <= 1'b1;
              end else begin
                key_err_q <= 1'b1;
              end
            end
          end
          ST_RELEASE: begin
            if (enc_chk_i) begin
              cnt_q <= '0;
            end else if (cnt_q < CNT_MAX) begin
              cnt_q <= cnt_q + NW'(1);
            end else begin
              cnt_q   <= '0;
              valid_q <= (count_q == COUNT_FULL);
              state_q <= (count_q == COUNT_FULL) ? ST_DONE : ST_IDLE;
            end
          end
          ST_DONE: begin
            // Entry frozen; keys ignored until the handshake completes.
            if (valid_q && ready_i) begin
              digits_q <= '0;
              count_q  <= '0;
              valid_q  <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign digits_o  = digits_q;
  assign count_o   = count_q;
  assign valid_o   = valid_q;
  assign key_ack_o = key_ack_q;
  assign key_err_o = key_err_q;

endmodule

// File: tb/tb_dec_key_entry_ctrl.sv
// Bench for dec_key_entry_ctrl: directed key sequences, a queue-based
// model of the entry rules compared every cycle, and literal checks.
module tb_dec_key_entry_ctrl;

  localparam int ND  = 4;
  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enc_b;
  logic        enc_chk;
  logic        clr;
  logic        ready;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        valid;
  logic        key_ack;
  logic        key_err;

  dec_key_entry_ctrl #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enc_b_i   (enc_b),
    .enc_chk_i (enc_chk),
    .clr_i     (clr),
    .ready_i   (ready),
    .digits_o  (digits),
    .count_o   (count),
    .valid_o   (valid),
    .key_ack_o (key_ack),
    .key_err_o (key_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int last_ack_cyc = 0;
  bit started = 0;

  // Model state: accepted digits, waiting-for-release flag, run lengths.
  int unsigned m_q[$];
  bit          m_valid = 0;
  bit          m_wait = 0;
  int          m_run = 0;
  int          m_low = 0;
  logic [3:0]  m_code = '0;
  bit          m_ack = 0;
  bit          m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] m_digits();
    logic [15:0] acc = '0;
    foreach (m_q[i]) acc = (acc << 4) | 16'(m_q[i]);
    return acc;
  endfunction

  // Model: a key counts once it has been seen down with the same code for
  // DEB consecutive samples; the next key needs DEB consecutive up samples.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      started = 1;
      m_ack = 0;
      m_err = 0;
      if (rst) begin
        m_q.delete(); m_valid = 0; m_wait = 0; m_run = 0; m_low = 0;
      end else if (clr) begin
        m_q.delete(); m_valid = 0; m_wait = 1; m_run = 0; m_low = 0;
      end else if (m_valid) begin
        if (ready) begin
          m_q.delete(); m_valid = 0;
        end
      end else if (m_wait) begin
        if (enc_chk) m_low = 0;
        else m_low++;
        if (m_low == DEB) begin
          m_wait = 0;
          m_low = 0;
          if (m_q.size() == ND) m_valid = 1;
        end
      end else if (enc_chk) begin
        if (m_run > 0 && enc_b == m_code) m_run++;
        else begin
          m_run = 1;
          m_code = enc_b;
        end
        if (m_run == DEB) begin
          if (m_code <= 9) begin
            m_q.push_back(int'(m_code));
            m_ack = 1;
          end else begin
            m_err = 1;
          end
          m_wait = 1;
          m_run = 0;
          m_low = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("digits", digits, m_digits());
        chk("count", count, m_q.size());
        chk("valid", valid, m_valid);
        chk("key_ack", key_ack, m_ack);
        chk("key_err", key_err, m_err);
        chk("ack_err_excl", key_ack & key_err, 0);
        if (key_ack === 1'b1) begin
          ack_cnt++;
          last_ack_cyc = cyc;
        end
        if (key_err === 1'b1) err_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic c, input int n);
    enc_b = b;
    enc_chk = c;
    step(n);
  endtask

  task automatic do_reset();
    rst = 1; clr = 0; ready = 0; enc_chk = 0; enc_b = 0;
    step(2);
    rst = 0;
    ack_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic key(input logic [3:0] d);
    drive(d, 1'b1, 20);
    drive(4'd0, 1'b0, 20);
  endtask

  int start;

  initial begin
    rst = 1; clr = 0; ready = 0; enc_chk = 0; enc_b = 0;
    do_reset();
    chk("reset_digits", digits, 16'h0000);
    chk("reset_count", count, 0);
    chk("reset_valid", valid, 0);

    // 1: single key 5, ack on the 16th sampling edge
    start = cyc;
    drive(4'd5, 1'b1, 20);
    chk("t1_ack_cnt", ack_cnt, 1);
    chk("t1_ack_edge", last_ack_cyc - start, 16);
    drive(4'd0, 1'b0, 20);
    chk("t1_count", count, 1);
    chk("t1_digits", digits, 16'h0005);

    // 2: full entry 1234, hold without ready, then handshake
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("t2_valid", valid, 1);
    chk("t2_digits", digits, 16'h1234);
    drive(4'd9, 1'b1, 50);
    chk("t2_hold_valid", valid, 1);
    chk("t2_hold_digits", digits, 16'h1234);
    chk("t2_hold_count", count, 4);
    enc_chk = 0;
    ready = 1;
    step(1);
    ready = 0;
    chk("t2_xfer_valid", valid, 0);
    chk("t2_xfer_count", count, 0);
    chk("t2_xfer_digits", digits, 16'h0000);
    step(5);

    // 3: glitch during press restarts detection
    do_reset();
    drive(4'd7, 1'b1, 10);
    drive(4'd7, 1'b0, 1);
    start = cyc;
    drive(4'd7, 1'b1, 16);
    drive(4'd0, 1'b0, 20);
    chk("t3_ack_cnt", ack_cnt, 1);
    chk("t3_ack_edge", last_ack_cyc - start, 16);
    chk("t3_count", count, 1);

    // 4: invalid code rejected, buffer untouched
    drive(4'hF, 1'b1, 16);
    drive(4'd0, 1'b0, 20);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_ack_cnt", ack_cnt, 1);
    chk("t4_count", count, 1);
    chk("t4_digits", digits, 16'h0007);

    // 5: long hold of key 0 captured once
    do_reset();
    drive(4'd0, 1'b1, 200);
    drive(4'd0, 1'b0, 20);
    chk("t5_ack_cnt", ack_cnt, 1);
    chk("t5_digit0", digits[3:0], 4'h0);
    chk("t5_count", count, 1);

    // 6: CLR beats READY; RST during PRESS
    do_reset();
    key(4'd9); key(4'd8); key(4'd0); key(4'd6);
    chk("t6_valid", valid, 1);
    chk("t6_digits", digits, 16'h9806);
    clr = 1;
    ready = 1;
    step(1);
    clr = 0;
    ready = 0;
    chk("t6_clr_valid", valid, 0);
    chk("t6_clr_count", count, 0);
    chk("t6_clr_digits", digits, 16'h0000);
    drive(4'd0, 1'b0, 20);
    drive(4'd3, 1'b1, 10);
    rst = 1;
    step(1);
    rst = 0;
    enc_chk = 0;
    chk("t6_rst_digits", digits, 16'h0000);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_ack", key_ack, 0);
    chk("t6_rst_err", key_err, 0);
    // After reset the same key must again need a full debounce.
    drive(4'd3, 1'b1, 20);
    drive(4'd0, 1'b0, 20);
    chk("t6_after_count", count, 1);
    chk("t6_after_digits", digits, 16'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
